// File: rtl/msrv32_pc_pipe_reg.sv
// Fetch PC register with valid/ready handoff and a DEPTH-stage (PC, valid)
// tracking pipeline so downstream stages know which instruction they carry.
module msrv32_pc_pipe_reg #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] BOOT_ADDR = '0,
   parameter int unsigned     IALIGN    = 4,
   parameter int unsigned     DEPTH     = 2
) (
   input  logic                  ms_riscv32_mp_clk_in,
   input  logic                  ms_riscv32_mp_rst_in,
   input  logic [XLEN-1:0]       pc_mux_in,
   input  logic                  redirect_in,
   input  logic                  stall_in,
   input  logic                  flush_in,
   input  logic                  fetch_ready_in,
   output logic [XLEN-1:0]       pc_out,
   output logic                  pc_valid_out,
   output logic [XLEN-1:0]       pc_plus_out,
   output logic [DEPTH*XLEN-1:0] stage_pc_out,
   output logic [DEPTH-1:0]      stage_valid_out,
   output logic                  misaligned_out
);

   localparam int unsigned ALIGN_BITS = $clog2(IALIGN);

   logic [XLEN-1:0]       pc_q;
   logic                  pc_valid_q;
   logic                  misaligned_q;
   logic [DEPTH*XLEN-1:0] stage_pc_q;
   logic [DEPTH-1:0]      stage_valid_q;
   logic [DEPTH*XLEN-1:0] stage_pc_shift;
   logic [DEPTH-1:0]      stage_valid_shift;
   logic [XLEN-1:0]       aligned_target;
   logic                  target_misaligned;
   logic                  fire;

   always_comb begin
      fire              = pc_valid_q & fetch_ready_in & ~stall_in & ~redirect_in;
      aligned_target    = {pc_mux_in[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
      target_misaligned = |pc_mux_in[ALIGN_BITS-1:0];
      pc_plus_out       = pc_q + XLEN'(IALIGN);
   end

   // A single stage has nothing older to shift in, so it only takes the fetch slot.
   generate
      if (DEPTH == 1) begin : g_one_stage
         always_comb begin
            stage_pc_shift    = pc_q;
            stage_valid_shift = fire;
         end
      end else begin : g_multi_stage
         always_comb begin
            stage_pc_shift    = {stage_pc_q[(DEPTH-1)*XLEN-1:0], pc_q};
            stage_valid_shift = {stage_valid_q[DEPTH-2:0], fire};
         end
      end
   endgenerate

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         pc_q          <= BOOT_ADDR;
         pc_valid_q    <= 1'b0;
         misaligned_q  <= 1'b0;
         stage_pc_q    <= '0;
         stage_valid_q <= '0;
      end else begin
         pc_valid_q   <= 1'b1;
         misaligned_q <= redirect_in & target_misaligned;

         if (redirect_in)
            pc_q <= aligned_target;
         else if (!stall_in && fire)
            pc_q <= pc_plus_out;

         // Flush clears validity but leaves stage PCs where they are.
         if (flush_in) begin
            stage_valid_q <= '0;
         end else if (!stall_in) begin
            stage_pc_q    <= stage_pc_shift;
            stage_valid_q <= stage_valid_shift;
         end
      end
   end

   always_comb begin
      pc_out          = pc_q;
      pc_valid_out    = pc_valid_q;
      misaligned_out  = misaligned_q;
      stage_pc_out    = stage_pc_q;
      stage_valid_out = stage_valid_q;
   end

endmodule

// File: tb/tb_msrv32_pc_pipe_reg.sv
// Directed bench: a vector table for the default configuration plus
// hand-written sequences for async reset and a DEPTH=4 / IALIGN=2 instance.
module tb_msrv32_pc_pipe_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- default instance: XLEN=32, IALIGN=4, DEPTH=2 ----------------
   logic        rst_n, redir, stall, flush, ready;
   logic [31:0] mux;
   logic [31:0] pc, pc_plus;
   logic        pc_valid, misal;
   logic [63:0] st_pc;
   logic [1:0]  st_v;

   msrv32_pc_pipe_reg #(.XLEN(32), .BOOT_ADDR(32'h0000_0000), .IALIGN(4), .DEPTH(2)) dut (
      .ms_riscv32_mp_clk_in(clk),
      .ms_riscv32_mp_rst_in(rst_n),
      .pc_mux_in(mux),
      .redirect_in(redir),
      .stall_in(stall),
      .flush_in(flush),
      .fetch_ready_in(ready),
      .pc_out(pc),
      .pc_valid_out(pc_valid),
      .pc_plus_out(pc_plus),
      .stage_pc_out(st_pc),
      .stage_valid_out(st_v),
      .misaligned_out(misal)
   );

   // ---------------- second instance: IALIGN=2, DEPTH=4, non-zero boot ----------------
   logic         rst2_n, redir2, stall2, flush2, ready2;
   logic [31:0]  mux2;
   logic [31:0]  pc2, pc2_plus;
   logic         pc2_valid, misal2;
   logic [127:0] st2_pc;
   logic [3:0]   st2_v;

   msrv32_pc_pipe_reg #(.XLEN(32), .BOOT_ADDR(32'h0000_1000), .IALIGN(2), .DEPTH(4)) dut2 (
      .ms_riscv32_mp_clk_in(clk),
      .ms_riscv32_mp_rst_in(rst2_n),
      .pc_mux_in(mux2),
      .redirect_in(redir2),
      .stall_in(stall2),
      .flush_in(flush2),
      .fetch_ready_in(ready2),
      .pc_out(pc2),
      .pc_valid_out(pc2_valid),
      .pc_plus_out(pc2_plus),
      .stage_pc_out(st2_pc),
      .stage_valid_out(st2_v),
      .misaligned_out(misal2)
   );

   typedef struct {
      logic        redir, stall, flush, ready;
      logic [31:0] mux;
      logic [31:0] pc;
      logic        pv, m;
      logic [31:0] s0pc;
      logic        s0v;
      logic [31:0] s1pc;
      logic        s1v;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic s, input logic f, input logic rd,
                               input logic [31:0] mx, input logic [31:0] epc, input logic em,
                               input logic [31:0] e0pc, input logic e0v,
                               input logic [31:0] e1pc, input logic e1v);
      vec_t v;
      v.redir = r; v.stall = s; v.flush = f; v.ready = rd; v.mux = mx;
      v.pc = epc; v.pv = 1'b1; v.m = em;
      v.s0pc = e0pc; v.s0v = e0v; v.s1pc = e1pc; v.s1v = e1v;
      return v;
   endfunction

   vec_t vt[20];

   initial begin
      logic [31:0] exp_pc;
      //           redir stall flush ready  mux           pc            m    s0pc          s0v  s1pc          s1v
      vt[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b0); // boot bubble
      vt[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h4,        1'b0, 32'h0,        1'b1, 32'h0,        1'b0);
      vt[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h8,        1'b0, 32'h4,        1'b1, 32'h0,        1'b1);
      vt[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        1'b0, 32'h8,        1'b0, 32'h4,        1'b1); // backpressure
      vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        1'b0, 32'h8,        1'b0, 32'h8,        1'b0);
      vt[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        1'b0, 32'h8,        1'b0, 32'h8,        1'b0);
      vt[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'hC,        1'b0, 32'h8,        1'b1, 32'h8,        1'b0);
      vt[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h10,       1'b0, 32'hC,        1'b1, 32'h8,        1'b1);
      vt[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h10,       1'b0, 32'hC,        1'b1, 32'h8,        1'b1); // stall
      vt[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h10,       1'b0, 32'hC,        1'b1, 32'h8,        1'b1);
      vt[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h100,      32'h100,      1'b0, 32'hC,        1'b1, 32'h8,        1'b1); // redirect over stall
      vt[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h203,      32'h200,      1'b1, 32'h100,      1'b0, 32'hC,        1'b1); // misaligned
      vt[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h204,      1'b0, 32'h200,      1'b1, 32'h100,      1'b0);
      vt[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h208,      1'b0, 32'h204,      1'b1, 32'h200,      1'b1);
      vt[14] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h300,      32'h300,      1'b0, 32'h204,      1'b0, 32'h200,      1'b0); // flush + redirect
      vt[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h304,      1'b0, 32'h300,      1'b1, 32'h204,      1'b0);
      vt[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h308,      1'b0, 32'h304,      1'b1, 32'h300,      1'b1);
      vt[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h308,     1'b0, 32'h304,      1'b1); // wrap setup
      vt[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 32'hFFFF_FFFC, 1'b1, 32'h308,     1'b0);
      vt[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h41,       32'h40,       1'b1, 32'h0,        1'b0, 32'hFFFF_FFFC, 1'b1);

      rst_n = 1'b0; redir = 1'b0; stall = 1'b0; flush = 1'b0; ready = 1'b1; mux = '0;
      rst2_n = 1'b0; redir2 = 1'b0; stall2 = 1'b0; flush2 = 1'b0; ready2 = 1'b1; mux2 = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, pc_valid}, 32'h0);
      chk("rst_stage_v", {30'b0, st_v}, 32'h0);
      chk("rst_stage0_pc", st_pc[31:0], 32'h0);
      chk("rst_misal", {31'b0, misal}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         redir = vt[i].redir; stall = vt[i].stall; flush = vt[i].flush;
         ready = vt[i].ready; mux = vt[i].mux;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pc", i), pc, vt[i].pc);
         chk($sformatf("v%0d_pc_plus", i), pc_plus, vt[i].pc + 32'd4);
         chk($sformatf("v%0d_valid", i), {31'b0, pc_valid}, {31'b0, vt[i].pv});
         chk($sformatf("v%0d_misal", i), {31'b0, misal}, {31'b0, vt[i].m});
         chk($sformatf("v%0d_s0pc", i), st_pc[31:0], vt[i].s0pc);
         chk($sformatf("v%0d_s1pc", i), st_pc[63:32], vt[i].s1pc);
         chk($sformatf("v%0d_sv", i), {30'b0, st_v}, {30'b0, vt[i].s1v, vt[i].s0v});
      end

      // Asynchronous reset between edges, while misaligned is high and pc=0x40
      redir = 1'b0; ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_pc", pc, 32'h0);
      chk("async_valid", {31'b0, pc_valid}, 32'h0);
      chk("async_misal", {31'b0, misal}, 32'h0);
      chk("async_stage_v", {30'b0, st_v}, 32'h0);
      chk("async_stage1_pc", st_pc[63:32], 32'h0);

      // ---------------- DEPTH=4 / IALIGN=2 sequence ----------------
      @(posedge clk);
      #1;
      chk("d4_rst_pc", pc2, 32'h0000_1000);
      chk("d4_rst_valid", {31'b0, pc2_valid}, 32'h0);
      rst2_n = 1'b1;
      // Edge 1 is the boot bubble; fires from edge 2 onward.
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         exp_pc = (k == 1) ? 32'h0000_1000 : 32'h0000_1000 + 32'(2 * (k - 1));
         chk($sformatf("d4_e%0d_pc", k), pc2, exp_pc);
         chk($sformatf("d4_e%0d_pc_plus", k), pc2_plus, exp_pc + 32'd2);
         for (int s = 0; s < 4; s++) begin
            if (k - 2 - s >= 0) begin
               chk($sformatf("d4_e%0d_s%0d_v", k, s), {31'b0, st2_v[s]}, 32'h1);
               chk($sformatf("d4_e%0d_s%0d_pc", k, s), st2_pc[s*32 +: 32],
                   32'h0000_1000 + 32'(2 * (k - 2 - s)));
            end else begin
               chk($sformatf("d4_e%0d_s%0d_v", k, s), {31'b0, st2_v[s]}, 32'h0);
            end
         end
      end
      // pc2 = 0x100C now; IALIGN=2 only masks bit 0
      redir2 = 1'b1; mux2 = 32'h0000_2003;
      @(posedge clk);
      #1;
      chk("d4_redir_pc", pc2, 32'h0000_2002);
      chk("d4_redir_misal", {31'b0, misal2}, 32'h1);
      chk("d4_redir_s0v", {31'b0, st2_v[0]}, 32'h0);
      mux2 = 32'h0000_3002;
      @(posedge clk);
      #1;
      chk("d4_aligned_pc", pc2, 32'h0000_3002);
      chk("d4_aligned_misal", {31'b0, misal2}, 32'h0);
      redir2 = 1'b0;
      @(posedge clk);
      #1;
      chk("d4_step_pc", pc2, 32'h0000_3004);
      chk("d4_step_s0", st2_pc[31:0], 32'h0000_3002);
      chk("d4_step_sv", {28'b0, st2_v}, 32'h0000_0009);
      #2 rst2_n = 1'b0;
      #1;
      chk("d4_async_pc", pc2, 32'h0000_1000);
      chk("d4_async_sv", {28'b0, st2_v}, 32'h0);
      chk("d4_async_valid", {31'b0, pc2_valid}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/msrv32_pc_pipe_reg.md
Name: msrv32_pc_pipe_reg

Overview:
Parametrised program-counter register block for the msrv32 core, generalising the single PC register.
- Holds the fetch PC and advances it sequentially.
- Accepts redirects from the PC mux, stall and flush.
- Hands the PC to fetch with a valid/ready handshake.
- Carries a DEPTH-stage shift pipeline of (PC, valid) pairs so later stages know which instruction they hold.
- Sits between the PC mux and the instruction-fetch interface.

Parameters:
XLEN, 32, datapath/PC width in bits.
BOOT_ADDR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
IALIGN, 4, instruction alignment and sequential increment in bytes (power of 2: 2 or 4).
DEPTH, 2, number of PC-tracking pipeline stages (1..8).

Ports:
ms_riscv32_mp_clk_in  input  1  clock, rising-edge
ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-low
pc_mux_in  input  XLEN  redirect target from PC mux
redirect_in  input  1  load pc_mux_in as next PC
stall_in  input  1  hold PC and all stages
flush_in  input  1  invalidate all tracking stages
fetch_ready_in  input  1  fetch accepts pc_out this cycle
pc_out  output  XLEN  current fetch PC
pc_valid_out  output  1  pc_out is a valid fetch request
pc_plus_out  output  XLEN  pc_out + IALIGN, combinational
stage_pc_out  output  DEPTH*XLEN  stage i PC at bits [i*XLEN +: XLEN]
stage_valid_out  output  DEPTH  stage i valid bit
misaligned_out  output  1  last redirect target was misaligned, one-cycle pulse

Behaviour:
Reset (rst_in low, asynchronous, takes effect immediately, including mid-operation):
- pc_out = BOOT_ADDR; pc_valid_out = 0.
- stage_pc_out = 0; stage_valid_out = 0; misaligned_out = 0.

Boot bubble:
- On the first rising edge with rst_in high, pc_valid_out <= 1.
- pc_valid_out then stays 1 until the next reset.

Handshake:
- fire = pc_valid_out & fetch_ready_in & ~stall_in & ~redirect_in.
- pc_out must stay stable while pc_valid_out=1 and fire=0, unless redirect_in=1.

Next-PC priority, evaluated each rising edge:
1. redirect_in=1: pc_out <= pc_mux_in with low log2(IALIGN) bits forced to 0. Ignores stall_in and fetch_ready_in.
2. else stall_in=1: pc_out holds.
3. else fire=1: pc_out <= pc_out + IALIGN, modulo 2^XLEN. Example: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
4. else: hold.

Misaligned detection:
- misaligned_out <= redirect_in & (pc_mux_in[log2(IALIGN)-1:0] != 0).
- Registered; high for exactly one cycle per offending redirect.

Tracking pipeline:
- flush_in=1: all stage_valid <= 0 and stage PCs hold. Flush overrides shift and stall.
- else stall_in=1: all stages hold.
- else shift: stage[i] <= stage[i-1] for i>=1, and stage[0] <= {pc_out, fire}.
- redirect_in=1 without flush or stall: shift occurs with stage0 valid = 0, because fire=0 discards the in-flight PC.
- Redirect and flush in the same cycle: PC loads the target and all stages invalidate.
- stage_pc of an invalid stage is don't-care for consumers, but must be deterministic: it takes the shifted value.

Latency:
- Accepted PC appears in stage0 one cycle after fire, and in stage i after i+1 cycles with no stall.

Combinational path:
- pc_plus_out = pc_out + IALIGN, truncated to XLEN bits.

Test Plan:
- Reset/boot: hold rst_in=0 for 3 cycles, then release with fetch_ready_in=1 -> pc_out=0, pc_valid_out 0 then 1; next edges pc_out=4, 8, 12; stage0 PC=0 valid=1 two edges after release; stage1 PC=0 valid=1 one edge later.
- Backpressure/stall: fetch_ready_in=0 for 3 cycles at pc_out=8 -> pc_out holds 8, stage0 valid=0 bubbles. stall_in=1 for 2 cycles -> pc_out and all stage PCs/valids frozen.
- Redirect vs stall: stall_in=1, redirect_in=1, pc_mux_in=32'h0000_0100 -> pc_out=0x100 next edge, stages hold. Then pc_mux_in=32'h0000_0203 with redirect -> pc_out=0x200, misaligned_out=1 for one cycle.
- Flush plus redirect same cycle with both stages valid -> stage_valid_out=2'b00 next edge, pc_out=target. Subsequent fires refill stage0 then stage1 in order.
- Wrap-around: redirect to 32'hFFFF_FFFC, fire -> pc_out=0, pc_plus_out=4, misaligned_out=0.
- Async reset mid-stream: assert rst_in low between clock edges while pc_out=0x40 -> outputs return to reset values immediately, without waiting for a clock edge. Repeat with DEPTH=4 and IALIGN=2: stepping is +2 and stage i is delayed i+1 cycles.
